xs3_to_bcd: RTL and testbench
=============================

XS3_TO_BCD -- requirements
Module: xs3_to_bcd

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  E3..E0 carry a code to convert this cycle.
REQ-005 E3  input  1  excess-3 code bit 3 (MSB).
REQ-006 E2  input  1  excess-3 code bit 2.
REQ-007 E1  input  1  excess-3 code bit 1.
REQ-008 E0  input  1  excess-3 code bit 0 (LSB).
REQ-009 B3  output  1  BCD digit bit 3 (MSB), registered.
REQ-010 B2  output  1  BCD digit bit 2, registered.
REQ-011 B1  output  1  BCD digit bit 1, registered.
REQ-012 B0  output  1  BCD digit bit 0 (LSB), registered.
REQ-013 out_valid  output  1  B3..B0 and err hold a fresh result; one-cycle pulse per accepted input.
REQ-014 err  output  1  accepted code was not a legal excess-3 digit.
REQ-015 err_cnt  output  8  count of illegal codes accepted since reset, saturating.

Function
REQ-016 E = {E3,E2,E1,E0} as unsigned 4-bit value; B = {B3,B2,B1,B0}.
REQ-017 Legal codes: E in 3..12 inclusive; converted digit = E - 3 (range 0..9), computed modulo 16 in 4 bits.
REQ-018 Illegal codes: E in {0,1,2,13,14,15}; B SHALL be 0000 and err SHALL be 1 for that result.
REQ-019 Latency: exactly one clock; input sampled at edge N with in_valid=1 appears on B/err with out_valid=1 after edge N.
REQ-020 in_valid=1 every cycle SHALL give one result per cycle (full throughput, no stall, no ready signal).
REQ-021 Cycle with in_valid=0: out_valid=0 on the next cycle; B and err hold their previous values.
REQ-022 err SHALL be 0 for every legal code result.
REQ-023 err_cnt increments by 1 on each accepted illegal code (in_valid=1 and E illegal), updating on the same edge as the result.
REQ-024 err_cnt saturates at 255; further illegal codes leave it at 255, no wrap.
REQ-025 Conversion is purely a function of the sampled E; there is no dependence on previous codes.
REQ-026 No combinational path from inputs to outputs; all outputs are flop outputs.

Reset
REQ-027 rst=1 at a rising edge SHALL set B=0000, out_valid=0, err=0, err_cnt=0, regardless of in_valid.
REQ-028 rst takes priority over any input sampled on the same edge; that input is discarded and produces no result.
REQ-029 The first edge with rst=0 SHALL accept input normally; its result appears on the following cycle.
REQ-030 Reset asserted mid-stream SHALL drop any result not yet presented.

Verification
REQ-031 Sweep E=0011..1100 with in_valid=1 back-to-back -> B=0000..1001 in order, one cycle later, out_valid=1 each cycle, err=0, err_cnt=0.
REQ-032 E=0000, 0001, 0010, 1101, 1110, 1111 with in_valid=1 -> B=0000, err=1, out_valid=1 each; err_cnt=6 afterwards.
REQ-033 E=1000 with in_valid=0 after a result of 0101 -> out_valid=0, B holds 0101, err_cnt unchanged.
REQ-034 300 consecutive illegal codes (E=1111) -> err_cnt reaches 255 and stays there; err=1 each result.
REQ-035 rst=1 on the same edge as E=0111, in_valid=1 -> next cycle B=0000, out_valid=0, err=0, err_cnt=0.
REQ-036 Alternate legal/illegal codes (E=0100, 1110, 1001) -> B=0001/0000/0110, err=0/1/0, err_cnt increments only once.

Source files
------------

// File: rtl/xs3_to_bcd.sv
// xs3_to_bcd: registered excess-3 to BCD digit converter with saturating illegal-code counter
module xs3_to_bcd (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       E3,
  input  logic       E2,
  input  logic       E1,
  input  logic       E0,
  output logic       B3,
  output logic       B2,
  output logic       B1,
  output logic       B0,
  output logic       out_valid,
  output logic       err,
  output logic [7:0] err_cnt
);
  logic [3:0] e;
  logic [3:0] b;
  logic       legal;
  assign e = {E3, E2, E1, E0};
  assign legal = (e >= 4'd3) && (e <= 4'd12);
  assign {B3, B2, B1, B0} = b;
  always_ff @(posedge clk) begin
    if (rst) begin
      b         <= 4'd0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        b   <= legal ? e - 4'd3 : 4'd0;
        err <= !legal;
        if (!legal && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_xs3_to_bcd.sv
// tb_xs3_to_bcd: table, directed and randomized self-checking bench for xs3_to_bcd
module tb_xs3_to_bcd;
  logic clk = 1'b0;
  logic rst, in_valid, E3, E2, E1, E0;
  logic B3, B2, B1, B0, out_valid, err;
  logic [7:0] err_cnt;
  int n_chk = 0;
  int n_fail = 0;
  int m_b = 0, m_err = 0, m_ov = 0, m_cnt = 0;

  typedef struct {
    logic [3:0] e;
    logic [3:0] b;
    logic       err;
  } vec_t;
  vec_t tbl[16];

  xs3_to_bcd dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .E3(E3), .E2(E2), .E1(E1), .E0(E0),
    .B3(B3), .B2(B2), .B1(B1), .B0(B0),
    .out_valid(out_valid), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] e);
    rst = r;
    in_valid = v;
    {E3, E2, E1, E0} = e;
    @(posedge clk);
    #1;
    if (r) begin
      m_b = 0; m_err = 0; m_ov = 0; m_cnt = 0;
    end else begin
      m_ov = v;
      if (v) begin
        if (e >= 3 && e <= 12) begin
          m_b = int'(e) - 3;
          m_err = 0;
        end else begin
          m_b = 0;
          m_err = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
  endtask

  task automatic check_model(input string name);
    check({name, "_b"}, int'({B3, B2, B1, B0}), m_b);
    check({name, "_err"}, int'(err), m_err);
    check({name, "_ov"}, int'(out_valid), m_ov);
    check({name, "_cnt"}, int'(err_cnt), m_cnt);
  endtask

  task automatic check_out(input string name, input int b, input int e, input int ov, input int cnt);
    check({name, "_b"}, int'({B3, B2, B1, B0}), b);
    check({name, "_err"}, int'(err), e);
    check({name, "_ov"}, int'(out_valid), ov);
    check({name, "_cnt"}, int'(err_cnt), cnt);
  endtask

  initial begin
    for (int i = 0; i < 10; i++) tbl[i] = '{e: 4'(i + 3), b: 4'(i), err: 1'b0};
    tbl[10] = '{4'b0000, 4'b0000, 1'b1};
    tbl[11] = '{4'b0001, 4'b0000, 1'b1};
    tbl[12] = '{4'b0010, 4'b0000, 1'b1};
    tbl[13] = '{4'b1101, 4'b0000, 1'b1};
    tbl[14] = '{4'b1110, 4'b0000, 1'b1};
    tbl[15] = '{4'b1111, 4'b0000, 1'b1};

    drive(1, 1, 4'b1111);
    drive(1, 0, 4'b0000);
    check_out("reset", 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      drive(0, 1, tbl[i].e);
      check($sformatf("tbl%0d_b", i), int'({B3, B2, B1, B0}), int'(tbl[i].b));
      check($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].err));
      check($sformatf("tbl%0d_ov", i), int'(out_valid), 1);
      if (i == 9) check("sweep_cnt", int'(err_cnt), 0);
    end
    check("illegal_cnt", int'(err_cnt), 6);

    drive(0, 1, 4'b1000);
    check_out("pre_hold", 5, 0, 1, 6);
    drive(0, 0, 4'b1000);
    check_out("hold", 5, 0, 0, 6);

    drive(1, 0, 4'b0000);
    drive(0, 1, 4'b0100);
    check_out("alt0", 1, 0, 1, 0);
    drive(0, 1, 4'b1110);
    check_out("alt1", 0, 1, 1, 1);
    drive(0, 1, 4'b1001);
    check_out("alt2", 6, 0, 1, 1);

    drive(1, 0, 4'b0000);
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, 4'b1111);
      check($sformatf("sat%0d_err", i), int'(err), 1);
      check($sformatf("sat%0d_cnt", i), int'(err_cnt), (i + 1 > 255) ? 255 : i + 1);
    end
    check("sat_final", int'(err_cnt), 255);

    drive(1, 1, 4'b0111);
    check_out("rst_collide", 0, 0, 0, 0);
    drive(0, 1, 4'b0111);
    check_out("first_after_rst", 4, 0, 1, 0);
    drive(0, 1, 4'b1001);
    drive(1, 1, 4'b0101);
    check_out("mid_rst", 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      check_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
